// File: rtl/wts_channel_sequencer_if.sv
// Bus between the register block / tone generator and the channel sequencer.
// The sequencer takes the slave side; whoever drives the slot strobe and generator results takes master.
interface wts_channel_sequencer_if #(
  parameter int CHANNELS = 8,
  parameter int CH_BITS  = 3
);
  logic                slot_enable;
  logic [CHANNELS-1:0] key_on;
  logic [CHANNELS-1:0] restart_req;
  logic [CHANNELS-1:0] half_flag_clear;
  logic                tg_half_timing;
  logic [11:0]         tg_frequency_count_next;
  logic [6:0]          tg_wave_address_next;
  logic [CH_BITS-1:0]  channel;
  logic [11:0]         tg_frequency_count;
  logic [6:0]          tg_wave_address;
  logic [CHANNELS-1:0] half_flag;
  logic                frame_end;

  modport master (
    output slot_enable, key_on, restart_req, half_flag_clear,
    output tg_half_timing, tg_frequency_count_next, tg_wave_address_next,
    input  channel, tg_frequency_count, tg_wave_address, half_flag, frame_end
  );

  modport slave (
    input  slot_enable, key_on, restart_req, half_flag_clear,
    input  tg_half_timing, tg_frequency_count_next, tg_wave_address_next,
    output channel, tg_frequency_count, tg_wave_address, half_flag, frame_end
  );
endinterface

// File: rtl/wts_channel_sequencer.sv
// Per-channel tone state store that time-multiplexes channels through the shared tone generator,
// writing back its next-state results and tracking restarts and sticky half-buffer flags.
module wts_channel_sequencer #(
  parameter int CHANNELS = 8,
  parameter int CH_BITS  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  wts_channel_sequencer_if.slave bus
);

  localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(CHANNELS - 1);

  logic [CH_BITS-1:0]  channel_q, channel_d;
  logic [11:0]         fcount_q [CHANNELS];
  logic [11:0]         fcount_d [CHANNELS];
  logic [6:0]          waddr_q  [CHANNELS];
  logic [6:0]          waddr_d  [CHANNELS];
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic [CHANNELS-1:0] half_flag_q, half_flag_d;
  logic                frame_end_q, frame_end_d;

  logic                cur_key;
  logic                eff_restart;
  logic                park;

  // A parked or restarting channel is forced back to the start of its waveform.
  function automatic logic [11:0] next_count(input logic park_i, input logic [11:0] nxt);
    return park_i ? 12'd0 : nxt;
  endfunction

  function automatic logic [6:0] next_addr(input logic park_i, input logic [6:0] nxt);
    return park_i ? 7'd0 : nxt;
  endfunction

  always_comb begin
    cur_key     = bus.key_on[channel_q];
    eff_restart = pending_q[channel_q] | bus.restart_req[channel_q];
    park        = !cur_key || eff_restart;

    fcount_d    = fcount_q;
    waddr_d     = waddr_q;
    channel_d   = channel_q;
    frame_end_d = 1'b0;
    pending_d   = pending_q | bus.restart_req;
    half_flag_d = half_flag_q & ~bus.half_flag_clear;

    if (bus.slot_enable) begin
      fcount_d[channel_q]  = next_count(park, bus.tg_frequency_count_next);
      waddr_d[channel_q]   = next_addr(park, bus.tg_wave_address_next);
      pending_d[channel_q] = 1'b0;
      // Setting beats a same-cycle clear so a half-buffer event is never lost.
      if (cur_key && !eff_restart && bus.tg_half_timing) begin
        half_flag_d[channel_q] = 1'b1;
      end
      channel_d   = (channel_q == LAST_CH) ? '0 : channel_q + 1'b1;
      frame_end_d = (channel_q == LAST_CH);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      channel_q   <= '0;
      pending_q   <= '0;
      half_flag_q <= '0;
      frame_end_q <= 1'b0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        fcount_q[ch] <= 12'd0;
        waddr_q[ch]  <= 7'd0;
      end
    end else begin
      channel_q   <= channel_d;
      pending_q   <= pending_d;
      half_flag_q <= half_flag_d;
      frame_end_q <= frame_end_d;
      fcount_q    <= fcount_d;
      waddr_q     <= waddr_d;
    end
  end

  assign bus.channel            = channel_q;
  assign bus.tg_frequency_count = fcount_q[channel_q];
  assign bus.tg_wave_address    = waddr_q[channel_q];
  assign bus.half_flag          = half_flag_q;
  assign bus.frame_end          = frame_end_q;

endmodule

// File: tb/tb_wts_channel_sequencer.sv
// Directed table-driven bench for wts_channel_sequencer (8 channels), plus mid-frame reset sequences.
module tb_wts_channel_sequencer;

  logic clk;
  logic reset;

  wts_channel_sequencer_if #(.CHANNELS(8), .CH_BITS(3)) bus_if ();

  wts_channel_sequencer #(.CHANNELS(8), .CH_BITS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        slot;
    logic [7:0]  key;
    logic [7:0]  rr;
    logic [7:0]  clr;
    logic        ht;
    logic [11:0] fn;
    logic [6:0]  an;
    logic [2:0]  e_ch;
    logic [11:0] e_fc;
    logic [6:0]  e_wa;
    logic [7:0]  e_hf;
    logic        e_fe;
  } vec_t;

  vec_t vecs[35];
  int   n_tests;
  int   n_fail;

  function automatic vec_t mk(input logic slot, input logic [7:0] key, input logic [7:0] rr,
                              input logic [7:0] clr, input logic ht, input logic [11:0] fn,
                              input logic [6:0] an, input logic [2:0] ch, input logic [11:0] fc,
                              input logic [6:0] wa, input logic [7:0] hf, input logic fe);
    vec_t v;
    v.slot = slot; v.key = key; v.rr = rr; v.clr = clr; v.ht = ht; v.fn = fn; v.an = an;
    v.e_ch = ch; v.e_fc = fc; v.e_wa = wa; v.e_hf = hf; v.e_fe = fe;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [2:0] ch, input logic [11:0] fc,
                               input logic [6:0] wa, input logic [7:0] hf, input logic fe);
    check({tag, " channel"},   32'(bus_if.channel), 32'(ch));
    check({tag, " fcount"},    32'(bus_if.tg_frequency_count), 32'(fc));
    check({tag, " waddr"},     32'(bus_if.tg_wave_address), 32'(wa));
    check({tag, " half_flag"}, 32'(bus_if.half_flag), 32'(hf));
    check({tag, " frame_end"}, 32'(bus_if.frame_end), 32'(fe));
  endtask

  task automatic drive(input logic slot, input logic [7:0] key, input logic [7:0] rr,
                       input logic [7:0] clr, input logic ht, input logic [11:0] fn,
                       input logic [6:0] an);
    bus_if.slot_enable             = slot;
    bus_if.key_on                  = key;
    bus_if.restart_req             = rr;
    bus_if.half_flag_clear         = clr;
    bus_if.tg_half_timing          = ht;
    bus_if.tg_frequency_count_next = fn;
    bus_if.tg_wave_address_next    = an;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Frame 1: basic advance, a held cycle, set-beats-clear on ch4, restart of ch5 requested at ch1.
    vecs[0]  = mk(1, 8'hFF, 8'h00, 8'h00, 0, 12'h005, 7'd1, 0, 12'h000, 7'd0, 8'h00, 0);
    vecs[1]  = mk(1, 8'hFF, 8'h20, 8'h00, 0, 12'h005, 7'd1, 1, 12'h000, 7'd0, 8'h00, 0);
    vecs[2]  = mk(1, 8'hFF, 8'h00, 8'h00, 0, 12'h005, 7'd1, 2, 12'h000, 7'd0, 8'h00, 0);
    vecs[3]  = mk(0, 8'hFF, 8'h00, 8'h00, 0, 12'h005, 7'd1, 3, 12'h000, 7'd0, 8'h00, 0);
    vecs[4]  = mk(1, 8'hFF, 8'h00, 8'h00, 0, 12'h005, 7'd1, 3, 12'h000, 7'd0, 8'h00, 0);
    vecs[5]  = mk(1, 8'hFF, 8'h00, 8'h10, 1, 12'h005, 7'd1, 4, 12'h000, 7'd0, 8'h00, 0);
    vecs[6]  = mk(1, 8'hFF, 8'h00, 8'h00, 0, 12'h010, 7'd3, 5, 12'h000, 7'd0, 8'h10, 0);
    vecs[7]  = mk(1, 8'hFF, 8'h00, 8'h00, 0, 12'h005, 7'd1, 6, 12'h000, 7'd0, 8'h10, 0);
    vecs[8]  = mk(1, 8'hFF, 8'h00, 8'h00, 0, 12'h005, 7'd1, 7, 12'h000, 7'd0, 8'h10, 0);
    // Frame 2: clear alone, ch2 keyed off, restart coinciding with ch6 slot, ch0 requested twice.
    vecs[9]  = mk(1, 8'hFF, 8'h00, 8'h10, 0, 12'h006, 7'd2, 0, 12'h005, 7'd1, 8'h10, 1);
    vecs[10] = mk(1, 8'hFF, 8'h00, 8'h00, 0, 12'h006, 7'd2, 1, 12'h005, 7'd1, 8'h00, 0);
    vecs[11] = mk(1, 8'hFB, 8'h00, 8'h00, 1, 12'h7FF, 7'd9, 2, 12'h005, 7'd1, 8'h00, 0);
    vecs[12] = mk(1, 8'hFF, 8'h00, 8'h00, 0, 12'h006, 7'd2, 3, 12'h005, 7'd1, 8'h00, 0);
    vecs[13] = mk(1, 8'hFF, 8'h00, 8'h00, 0, 12'h006, 7'd2, 4, 12'h005, 7'd1, 8'h00, 0);
    vecs[14] = mk(1, 8'hFF, 8'h01, 8'h00, 0, 12'h010, 7'd3, 5, 12'h000, 7'd0, 8'h00, 0);
    vecs[15] = mk(1, 8'hFF, 8'h40, 8'h00, 0, 12'h006, 7'd2, 6, 12'h005, 7'd1, 8'h00, 0);
    vecs[16] = mk(1, 8'hFF, 8'h01, 8'h00, 0, 12'h006, 7'd2, 7, 12'h005, 7'd1, 8'h00, 0);
    // Frame 3: ch0 restarts, ch2 re-keyed from 0/0, ch5 shows the post-restart write.
    vecs[17] = mk(1, 8'hFF, 8'h00, 8'h00, 0, 12'h006, 7'd2, 0, 12'h006, 7'd2, 8'h00, 1);
    vecs[18] = mk(0, 8'hFF, 8'h00, 8'h00, 0, 12'h006, 7'd2, 1, 12'h006, 7'd2, 8'h00, 0);
    vecs[19] = mk(1, 8'hFF, 8'h00, 8'h00, 0, 12'h006, 7'd2, 1, 12'h006, 7'd2, 8'h00, 0);
    vecs[20] = mk(1, 8'hFF, 8'h00, 8'h00, 1, 12'h006, 7'd2, 2, 12'h000, 7'd0, 8'h00, 0);
    vecs[21] = mk(1, 8'hFF, 8'h00, 8'h00, 0, 12'h006, 7'd2, 3, 12'h006, 7'd2, 8'h04, 0);
    vecs[22] = mk(1, 8'hFF, 8'h00, 8'h00, 0, 12'h006, 7'd2, 4, 12'h006, 7'd2, 8'h04, 0);
    vecs[23] = mk(1, 8'hFF, 8'h00, 8'h00, 0, 12'h006, 7'd2, 5, 12'h010, 7'd3, 8'h04, 0);
    vecs[24] = mk(1, 8'hFF, 8'h00, 8'h00, 0, 12'h007, 7'd4, 6, 12'h000, 7'd0, 8'h04, 0);
    vecs[25] = mk(1, 8'hFF, 8'h00, 8'h00, 0, 12'h006, 7'd2, 7, 12'h006, 7'd2, 8'h04, 0);
    // Frame 4: pending flags must be gone, so every channel stores the generator values.
    vecs[26] = mk(1, 8'hFF, 8'h00, 8'h00, 0, 12'h008, 7'd5, 0, 12'h000, 7'd0, 8'h04, 1);
    vecs[27] = mk(1, 8'hFF, 8'h00, 8'h00, 0, 12'h006, 7'd2, 1, 12'h006, 7'd2, 8'h04, 0);
    vecs[28] = mk(1, 8'hFF, 8'h00, 8'h00, 0, 12'h006, 7'd2, 2, 12'h006, 7'd2, 8'h04, 0);
    vecs[29] = mk(1, 8'hFF, 8'h00, 8'h00, 0, 12'h006, 7'd2, 3, 12'h006, 7'd2, 8'h04, 0);
    vecs[30] = mk(1, 8'hFF, 8'h00, 8'h00, 0, 12'h006, 7'd2, 4, 12'h006, 7'd2, 8'h04, 0);
    vecs[31] = mk(1, 8'hFF, 8'h00, 8'h00, 0, 12'h006, 7'd2, 5, 12'h006, 7'd2, 8'h04, 0);
    vecs[32] = mk(1, 8'hFF, 8'h00, 8'h00, 0, 12'h006, 7'd2, 6, 12'h007, 7'd4, 8'h04, 0);
    vecs[33] = mk(1, 8'hFF, 8'h00, 8'h00, 0, 12'h006, 7'd2, 7, 12'h006, 7'd2, 8'h04, 0);
    vecs[34] = mk(0, 8'hFF, 8'h00, 8'h00, 0, 12'h006, 7'd2, 0, 12'h008, 7'd5, 8'h04, 1);

    reset = 1'b1;
    drive(0, 8'hFF, 8'h00, 8'h00, 0, 12'h000, 7'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outputs("reset", 3'd0, 12'h000, 7'd0, 8'h00, 1'b0);

    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      drive(vecs[i].slot, vecs[i].key, vecs[i].rr, vecs[i].clr, vecs[i].ht, vecs[i].fn, vecs[i].an);
      #1;
      check_outputs($sformatf("row%0d", i), vecs[i].e_ch, vecs[i].e_fc, vecs[i].e_wa,
                    vecs[i].e_hf, vecs[i].e_fe);
    end

    // Mid-frame reset at channel 3 with a live slot: all state must be discarded.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 8'hFF, 8'h00, 8'h00, 1, 12'h00A, 7'd6);
    end
    @(negedge clk);
    drive(1, 8'hFF, 8'h08, 8'h00, 1, 12'h00A, 7'd6);
    #1;
    check("pre_reset channel", 32'(bus_if.channel), 32'd3);
    check("pre_reset half_flag", 32'(bus_if.half_flag), 32'h07);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(0, 8'hFF, 8'h00, 8'h00, 0, 12'h000, 7'd0);
    #1;
    check_outputs("mid_reset", 3'd0, 12'h000, 7'd0, 8'h00, 1'b0);
    @(negedge clk);
    drive(1, 8'hFF, 8'h00, 8'h00, 0, 12'h00B, 7'd7);
    @(negedge clk);
    drive(0, 8'hFF, 8'h00, 8'h00, 0, 12'h000, 7'd0);
    #1;
    check_outputs("post_reset_ch1", 3'd1, 12'h000, 7'd0, 8'h00, 1'b0);

    // Reset during the last channel's slot must suppress the frame_end pulse.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1, 8'hFF, 8'h00, 8'h00, 0, 12'h00C, 7'd8);
    end
    @(negedge clk);
    #1;
    check("pre_reset2 channel", 32'(bus_if.channel), 32'd7);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(0, 8'hFF, 8'h00, 8'h00, 0, 12'h000, 7'd0);
    #1;
    check_outputs("reset_at_ch7", 3'd0, 12'h000, 7'd0, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wts_channel_sequencer.md
Name: wts_channel_sequencer

Overview:
- Holds per-channel tone state (12-bit frequency counter, 7-bit wave address) for all wave-table channels.
- Time-multiplexes that state through the shared combinational tone generator, one channel per slot, and writes back the generator's next-state results.
- Tracks key-on/off, sync-restart requests and sticky half-buffer flags for the CPU-facing register block.
- Sits between the register block and the tone generator; channel index and address go on to the wave memory and mixer.

Parameters:
- CHANNELS, 8, number of time-multiplexed channels (2..8)
- CH_BITS, 3, width of channel index; must satisfy 2**CH_BITS >= CHANNELS

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- slot_enable  input  1  one-cycle strobe: process current channel and advance
- key_on  input  CHANNELS  per-channel enable level from register block
- restart_req  input  CHANNELS  per-channel one-cycle request to restart the waveform at address 0
- half_flag_clear  input  CHANNELS  per-channel one-cycle clear of the sticky half flag
- tg_half_timing  input  1  half-buffer timing from tone generator for current channel
- tg_frequency_count_next  input  12  next counter value from tone generator
- tg_wave_address_next  input  7  next wave address from tone generator
- channel  output  CH_BITS  current slot channel index
- tg_frequency_count  output  12  stored counter of current channel, to tone generator
- tg_wave_address  output  7  stored wave address of current channel, to tone generator
- half_flag  output  CHANNELS  sticky per-channel half-buffer flags
- frame_end  output  1  one-cycle pulse after the last channel's slot is processed

Behaviour:
- Reset (synchronous, highest priority): channel=0; all counters=0; all addresses=0; restart pending=0; half_flag=0; frame_end=0. Reset asserted mid-frame discards in-progress state; no write-back occurs that cycle.
- State storage: register arrays fcount[CHANNELS] (12b), waddr[CHANNELS] (7b), pending[CHANNELS].
- tg_frequency_count = fcount[channel], tg_wave_address = waddr[channel]; combinational mux from registers, zero latency.
- On a cycle with slot_enable=1, channel c = current channel:
  - eff_restart = pending[c] | restart_req[c].
  - If key_on[c]=0: fcount[c]<=0, waddr[c]<=0 (channel parked).
  - Else if eff_restart: fcount[c]<=0, waddr[c]<=0.
  - Else: fcount[c]<=tg_frequency_count_next, waddr[c]<=tg_wave_address_next.
  - pending[c]<=0.
  - half_flag[c] is set if key_on[c]=1, eff_restart=0 and tg_half_timing=1.
  - channel <= (c==CHANNELS-1) ? 0 : c+1.
  - frame_end <= (c==CHANNELS-1).
- When slot_enable=0: no state write; channel holds; frame_end<=0. frame_end is therefore a registered pulse, exactly one cycle, in the cycle after the wrap.
- restart_req for a channel not currently being processed sets pending[ch]; it is held until that channel's next slot. Repeated requests before the slot collapse into one restart.
- restart_req[c] coinciding with c's slot is applied in that slot; pending[c] ends 0.
- half_flag_clear[ch] clears half_flag[ch]. A set in the same cycle wins, and the flag stays 1.
- key_on deasserted holds a channel at 0/0 every slot; on re-assertion it starts from address 0, count 0.
- tg_*_next values are used only in the slot_enable cycle. Width rules follow the generator: 12-bit and 7-bit wrap inside the generator, and no saturation is applied here.
- Channel indices >= CHANNELS never occur.

Test Plan:
- Reset then 3 slot_enable pulses with generator next values 12'h005/7'd1: channel sequence 0→1→2→3; fcount[0..2]=5, waddr[0..2]=1; frame_end stays 0.
- CHANNELS=8, 8 consecutive slot_enable: frame_end=1 in exactly the cycle after channel 7's slot; channel returns to 0.
- key_on[2]=0, generator drives 12'h7FF/7'd9 on channel 2's slot: fcount[2]=0, waddr[2]=0; no half_flag[2] even with tg_half_timing=1.
- restart_req[5] pulsed while channel=1, then slots run to channel 5 with next=12'h010/7'd3: channel 5 stores 0/0; pending cleared; the next frame stores 12'h010/7'd3.
- tg_half_timing=1 on channel 4's slot with half_flag_clear[4]=1 in the same cycle: half_flag[4]=1. A later clear alone gives half_flag[4]=0.
- Assert reset mid-frame at channel 3 with slot_enable=1: next cycle channel=0, all tg outputs 0, half_flag=0, frame_end=0.
